// File: rtl/mux_sel_arbiter.sv
// Round-robin arbiter that owns the select lines of a shared data selector
// and registers the selector output Y on behalf of the current owner.
module mux_sel_arbiter #(
    parameter int NREQ     = 3,
    parameter int MAX_HOLD = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NREQ-1:0] req,
    input  logic            y_in,
    output logic [NREQ-1:0] gnt,
    output logic [1:0]      sel,
    output logic            busy,
    output logic            y_q,
    output logic            y_valid,
    output logic [1:0]      y_idx
);

    localparam int HW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
    localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_HOLD - 1);

    localparam logic ST_IDLE  = 1'b0;
    localparam logic ST_GRANT = 1'b1;

    logic          state;
    logic [1:0]    owner;
    logic [1:0]    last;
    logic [1:0]    winner;
    logic [1:0]    cand;
    logic          found;
    logic [HW-1:0] hold_cnt;
    logic [3:0]    req_pad;
    logic          release_now;

    // Padding to four bits lets a 2-bit code index the request vector for any legal NREQ.
    assign req_pad = 4'(req);

    // Scan starts just after the previous owner, so that owner has lowest priority.
    always_comb begin
        winner = '0;
        cand   = '0;
        found  = 1'b0;
        for (int i = 1; i <= NREQ; i++) begin
            cand = 2'((int'(last) + i) % NREQ);
            if (!found && req_pad[cand]) begin
                found  = 1'b1;
                winner = cand;
            end
        end
    end

    assign release_now = !req_pad[owner] || (hold_cnt == HOLD_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            gnt      <= '0;
            sel      <= '0;
            busy     <= 1'b0;
            y_q      <= 1'b0;
            y_valid  <= 1'b0;
            y_idx    <= '0;
            hold_cnt <= '0;
            owner    <= '0;
            last     <= 2'(NREQ - 1);
        end else begin
            y_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (|req) begin
                        gnt      <= NREQ'(1) << winner;
                        sel      <= winner;
                        busy     <= 1'b1;
                        hold_cnt <= '0;
                        owner    <= winner;
                        state    <= ST_GRANT;
                    end
                end
                ST_GRANT: begin
                    y_q     <= y_in;
                    y_idx   <= owner;
                    y_valid <= 1'b1;
                    // sel is left alone on release so the selector never sees a spurious code.
                    if (release_now) begin
                        gnt   <= '0;
                        busy  <= 1'b0;
                        last  <= owner;
                        state <= ST_IDLE;
                    end else begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mux_sel_arbiter.sv
// Bench for mux_sel_arbiter: directed scenarios with literal expectations plus
// randomized traffic checked every cycle against a behavioural model.
module tb_mux_sel_arbiter;

    localparam int NREQ     = 3;
    localparam int MAX_HOLD = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] req;
    logic       y_in;
    logic [2:0] gnt;
    logic [1:0] sel;
    logic       busy;
    logic       y_q;
    logic       y_valid;
    logic [1:0] y_idx;
    logic [3:0] din;

    int total = 0;
    int bad   = 0;

    // Model state: owner is -1 when nobody holds the grant.
    int m_owner = -1;
    int m_held  = 0;
    int m_last  = NREQ - 1;
    int m_sel   = 0;
    int m_yq    = 0;
    int m_yv    = 0;
    int m_yidx  = 0;
    bit model_ok = 1'b0;

    mux_sel_arbiter #(.NREQ(NREQ), .MAX_HOLD(MAX_HOLD)) dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .y_in    (y_in),
        .gnt     (gnt),
        .sel     (sel),
        .busy    (busy),
        .y_q     (y_q),
        .y_valid (y_valid),
        .y_idx   (y_idx)
    );

    // The shared selector: each requester drives one data input, sel picks it.
    assign y_in = din[sel];

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [7:0] actual, input logic [7:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    // One clock edge of the arbiter as described by its rules.
    task automatic modelStep();
        if (rst) begin
            m_owner  = -1;
            m_held   = 0;
            m_last   = NREQ - 1;
            m_sel    = 0;
            m_yq     = 0;
            m_yv     = 0;
            m_yidx   = 0;
            model_ok = 1'b1;
        end else if (m_owner >= 0) begin
            m_yq   = int'(din[m_sel[1:0]]);
            m_yidx = m_owner;
            m_yv   = 1;
            m_held++;
            if (!req[m_owner[1:0]] || m_held >= MAX_HOLD) begin
                m_last  = m_owner;
                m_owner = -1;
            end
        end else begin
            m_yv = 0;
            if (req != 3'b000) begin
                for (int k = 1; k <= NREQ; k++) begin
                    int c;
                    c = (m_last + k) % NREQ;
                    if (m_owner < 0 && req[c[1:0]]) begin
                        m_owner = c;
                        m_sel   = c;
                        m_held  = 0;
                    end
                end
            end
        end
    endtask

    always @(posedge clk) begin
        modelStep();
        #1;
        if (model_ok) begin
            checkOutput("model_gnt",  8'(gnt),     (m_owner >= 0) ? 8'(1 << m_owner) : 8'h00);
            checkOutput("model_busy", 8'(busy),    (m_owner >= 0) ? 8'h01 : 8'h00);
            checkOutput("model_sel",  8'(sel),     8'(m_sel));
            checkOutput("model_yv",   8'(y_valid), 8'(m_yv));
            checkOutput("model_yq",   8'(y_q),     8'(m_yq));
            checkOutput("model_yidx", 8'(y_idx),   8'(m_yidx));
        end
    end

    task automatic applyStimulus(input logic r, input logic [2:0] rq, input logic [3:0] d);
        rst = r;
        req = rq;
        din = d;
        @(negedge clk);
    endtask

    initial begin
        logic [2:0] rq;
        rst = 1'b1;
        req = '0;
        din = '0;
        @(negedge clk);

        $display("[TB] single requester");
        applyStimulus(1'b1, 3'b000, 4'b0010);
        applyStimulus(1'b1, 3'b000, 4'b0010);
        checkOutput("reset_gnt",  8'(gnt),     8'h00);
        checkOutput("reset_busy", 8'(busy),    8'h00);
        checkOutput("reset_sel",  8'(sel),     8'h00);
        checkOutput("reset_yv",   8'(y_valid), 8'h00);
        applyStimulus(1'b0, 3'b010, 4'b0010);
        checkOutput("t1_gnt",  8'(gnt),  8'h02);
        checkOutput("t1_sel",  8'(sel),  8'h01);
        checkOutput("t1_busy", 8'(busy), 8'h01);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 3'b010, 4'b0010);
            checkOutput("t1_hold_gnt", 8'(gnt), 8'h02);
        end
        applyStimulus(1'b0, 3'b010, 4'b0010);
        checkOutput("t1_gap_gnt",  8'(gnt),  8'h00);
        checkOutput("t1_gap_busy", 8'(busy), 8'h00);
        checkOutput("t1_gap_sel",  8'(sel),  8'h01);
        applyStimulus(1'b0, 3'b010, 4'b0010);
        checkOutput("t1_regrant_gnt", 8'(gnt), 8'h02);

        $display("[TB] all requesting, datapath sampling");
        applyStimulus(1'b1, 3'b111, 4'b0010);
        applyStimulus(1'b1, 3'b111, 4'b0010);
        for (int n = 1; n <= 16; n++) begin
            int pos, grp;
            applyStimulus(1'b0, 3'b111, 4'b0010);
            pos = (n - 1) % 5;
            grp = ((n - 1) / 5) % 3;
            checkOutput("rr_gnt", 8'(gnt), (pos == 4) ? 8'h00 : 8'(1 << grp));
            checkOutput("rr_sel", 8'(sel), 8'(grp));
            if (n == 1) begin
                checkOutput("rr_yv_first", 8'(y_valid), 8'h00);
            end else begin
                pos = (n - 2) % 5;
                grp = ((n - 2) / 5) % 3;
                checkOutput("rr_yv", 8'(y_valid), (pos == 4) ? 8'h00 : 8'h01);
                if (pos != 4) begin
                    checkOutput("rr_yidx", 8'(y_idx), 8'(grp));
                    checkOutput("rr_yq",   8'(y_q),   (grp == 1) ? 8'h01 : 8'h00);
                end
            end
        end

        $display("[TB] early release");
        applyStimulus(1'b1, 3'b100, 4'b0100);
        applyStimulus(1'b1, 3'b100, 4'b0100);
        applyStimulus(1'b0, 3'b100, 4'b0100);
        checkOutput("t3_gnt1", 8'(gnt),     8'h04);
        checkOutput("t3_yv1",  8'(y_valid), 8'h00);
        applyStimulus(1'b0, 3'b100, 4'b0100);
        checkOutput("t3_gnt2",  8'(gnt),     8'h04);
        checkOutput("t3_yv2",   8'(y_valid), 8'h01);
        checkOutput("t3_yidx2", 8'(y_idx),   8'h02);
        applyStimulus(1'b0, 3'b000, 4'b0100);
        checkOutput("t3_gnt3",  8'(gnt),     8'h00);
        checkOutput("t3_yv3",   8'(y_valid), 8'h01);
        checkOutput("t3_yidx3", 8'(y_idx),   8'h02);
        checkOutput("t3_yq3",   8'(y_q),     8'h01);
        applyStimulus(1'b0, 3'b000, 4'b0100);
        checkOutput("t3_yv4", 8'(y_valid), 8'h00);

        $display("[TB] reset during grant");
        applyStimulus(1'b1, 3'b110, 4'b0000);
        applyStimulus(1'b1, 3'b110, 4'b0000);
        applyStimulus(1'b0, 3'b110, 4'b0000);
        checkOutput("t5_gnt1", 8'(gnt), 8'h02);
        applyStimulus(1'b0, 3'b110, 4'b0000);
        checkOutput("t5_gnt2", 8'(gnt), 8'h02);
        applyStimulus(1'b1, 3'b110, 4'b0000);
        checkOutput("t5_rst_gnt",  8'(gnt),     8'h00);
        checkOutput("t5_rst_busy", 8'(busy),    8'h00);
        checkOutput("t5_rst_yv",   8'(y_valid), 8'h00);
        applyStimulus(1'b0, 3'b110, 4'b0000);
        checkOutput("t5_after_gnt", 8'(gnt), 8'h02);

        $display("[TB] idle");
        applyStimulus(1'b0, 3'b000, 4'b0000);
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b0, 3'b000, 4'b0000);
            checkOutput("idle_gnt",  8'(gnt),     8'h00);
            checkOutput("idle_busy", 8'(busy),    8'h00);
            checkOutput("idle_yv",   8'(y_valid), 8'h00);
            checkOutput("idle_sel",  8'(sel),     8'h01);
        end

        $display("[TB] random traffic");
        rq = 3'b111;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 3) == 0) rq = 3'($urandom_range(0, 7));
            applyStimulus(($urandom_range(0, 59) == 0), rq, 4'($urandom_range(0, 15)));
        end

        @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
